// File: rtl/ext_mem_model_mc_if.sv
// Master memory bus between the HLS top (master) and the memory model (slave).
// Latency: none, wires only.
// Backpressure: none; completion is signalled per channel by M_DataRdy.
interface ext_mem_model_mc_if #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SIZE_W   = 4
);
    logic [CHANNELS-1:0]        Mout_oe_ram;
    logic [CHANNELS-1:0]        Mout_we_ram;
    logic [CHANNELS*ADDR_W-1:0] Mout_addr_ram;
    logic [CHANNELS*DATA_W-1:0] Mout_Wdata_ram;
    logic [CHANNELS*SIZE_W-1:0] Mout_data_ram_size;
    logic [CHANNELS*DATA_W-1:0] M_Rdata_ram;
    logic [CHANNELS-1:0]        M_DataRdy;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy
    );
endinterface

// File: rtl/ext_mem_model_mc.sv
// Multi-channel off-chip memory model answering the HLS master memory interface, with preload port.
// Latency: read DataRdy READ_DELAY-1 cycles after request, write DataRdy WRITE_DELAY-1 cycles after request.
// Backpressure: requester must hold oe/we until DataRdy; a dropped request aborts the access.
// Optional feature macro: EXT_MEM_ERR_EN enables the sticky per-channel err flags (tied to 0 otherwise).
module ext_mem_model_mc #(
    parameter int CHANNELS    = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SIZE_W      = 4,
    parameter int DEPTH       = 32,
    parameter int BASE_ADDR   = 0,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                clock,
    input  logic                reset,
    ext_mem_model_mc_if.slave   bus,
    input  logic                ld_en,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    output logic [CHANNELS-1:0] err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when an absolute address falls inside the served window.
    function automatic logic in_window(input logic [ADDR_W-1:0] a);
        return (32'(a) >= 32'(BASE_ADDR)) && (32'(a) < 32'(BASE_ADDR + DEPTH));
    endfunction

    // Word index inside the array for an in-range address.
    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(32'(a) - 32'(BASE_ADDR));
    endfunction

    // Low 'sz' bits set; sizes at or above DATA_W give a full-word mask.
    function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < DATA_W; b++) m[b] = (int'(sz) > b);
        return m;
    endfunction

    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] mem_d   [DEPTH];
    logic [1:0]        state_q [CHANNELS];
    logic [1:0]        state_d [CHANNELS];
    logic [31:0]       cnt_q   [CHANNELS];
    logic [31:0]       cnt_d   [CHANNELS];
    logic [DATA_W-1:0] rdata_q [CHANNELS];
    logic [DATA_W-1:0] rdata_d [CHANNELS];
    logic [CHANNELS-1:0] is_wr_q, is_wr_d;

    logic [ADDR_W-1:0] ch_addr  [CHANNELS];
    logic [DATA_W-1:0] ch_wdata [CHANNELS];
    logic [DATA_W-1:0] ch_mask  [CHANNELS];
    logic [IDX_W-1:0]  ch_idx   [CHANNELS];
    logic [CHANNELS-1:0] ch_in_rng, ch_wr_sel, ch_held, ch_last;
    logic [CHANNELS-1:0] ch_rdy, ch_commit, ch_rd_rdy;
    logic [CHANNELS*DATA_W-1:0] rdata_out;

    // Per-channel request decode: window check, index, mask, and whether the access is on its last cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_addr[i]   = bus.Mout_addr_ram[i*ADDR_W +: ADDR_W];
            ch_wdata[i]  = bus.Mout_Wdata_ram[i*DATA_W +: DATA_W];
            ch_mask[i]   = size_mask(bus.Mout_data_ram_size[i*SIZE_W +: SIZE_W]);
            ch_in_rng[i] = in_window(ch_addr[i]);
            ch_idx[i]    = to_idx(ch_addr[i]);
            // An access in flight keeps its original type; a fresh one prefers write if both strobes are up.
            ch_wr_sel[i] = (state_q[i] == ST_WAIT) ? is_wr_q[i] : bus.Mout_we_ram[i];
            if (state_q[i] == ST_WAIT)
                ch_held[i] = ch_in_rng[i] && (is_wr_q[i] ? bus.Mout_we_ram[i] : bus.Mout_oe_ram[i]);
            else
                ch_held[i] = ch_in_rng[i] && (bus.Mout_we_ram[i] || bus.Mout_oe_ram[i]);
            ch_last[i]   = (cnt_q[i] == (ch_wr_sel[i] ? 32'(WRITE_DELAY - 1) : 32'(READ_DELAY - 1)));
        end
    end

    // Per-channel access FSM; DONE accepts a new request exactly like IDLE.
    always_comb begin
        ch_rdy    = '0;
        ch_commit = '0;
        ch_rd_rdy = '0;
        is_wr_d   = is_wr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (ch_held[i]) begin
                if (ch_last[i]) begin
                    ch_rdy[i]  = !reset;
                    state_d[i] = ST_DONE;
                    cnt_d[i]   = '0;
                end else begin
                    state_d[i] = ST_WAIT;
                    cnt_d[i]   = cnt_q[i] + 32'd1;
                    is_wr_d[i] = ch_wr_sel[i];
                end
            end else begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end
            ch_commit[i] = ch_rdy[i] && ch_wr_sel[i];
            ch_rd_rdy[i] = ch_rdy[i] && !ch_wr_sel[i];
            rdata_d[i]   = (ch_in_rng[i] && bus.Mout_oe_ram[i]) ? mem_q[ch_idx[i]] : '0;
            rdata_out[i*DATA_W +: DATA_W] = ch_rd_rdy[i] ? rdata_q[i] : '0;
        end
    end

    // Next memory image: preload first, then channel commits in ascending order so the highest channel wins.
    always_comb begin
        mem_d = mem_q;
        if (ld_en && in_window(ld_addr))
            mem_d[to_idx(ld_addr)] = ld_data;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_commit[i])
                mem_d[ch_idx[i]] = (ch_wdata[i] & ch_mask[i]) | (mem_q[ch_idx[i]] & ~ch_mask[i]);
        end
    end

    // Channel state and read-data registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_wr_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            is_wr_q <= is_wr_d;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // Storage survives reset; commits are already suppressed while reset is high.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.M_DataRdy   = ch_rdy;
    assign bus.M_Rdata_ram = rdata_out;

`ifdef EXT_MEM_ERR_EN
    logic [CHANNELS-1:0] err_q, err_d;

    // Sticky protocol errors: both strobes, aborted access, or out-of-window request.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.Mout_oe_ram[i] && bus.Mout_we_ram[i])
                err_d[i] = 1'b1;
            if ((state_q[i] == ST_WAIT) && !ch_held[i])
                err_d[i] = 1'b1;
            if ((bus.Mout_oe_ram[i] || bus.Mout_we_ram[i]) && !ch_in_rng[i])
                err_d[i] = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = '0;
`endif
endmodule
